// File: rtl/systolic_input_feeder.sv
// Operand store + streamer for the systolic array: clears accumulators, feeds n A/B vector pairs plus n-1 zero flush vectors, waits for first finish.
// Latency: start at edge 0 -> clear pulse cycle 1, vector t in cycle 2+t; writes are accepted only while idle (o_wr_ready low otherwise).
module systolic_input_feeder #(
  parameter int SIZE   = 32,
  parameter int I_BITS = 8
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic                     i_wr_sel,
  input  logic [$clog2(SIZE)-1:0]  i_wr_addr,
  input  logic [SIZE*I_BITS-1:0]   i_wr_data,
  input  logic [2:0]               rf_matrix_size,
  input  logic                     i_start,
  input  logic                     i_first_finish,
  output logic                     o_array_reset,
  output logic                     o_valid,
  output logic [SIZE*I_BITS-1:0]   o_a_full,
  output logic [SIZE*I_BITS-1:0]   o_b_full,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int AW = $clog2(SIZE);
  localparam int VW = SIZE * I_BITS;
  localparam int CW = $clog2(2 * SIZE);

  typedef logic [VW-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] t_q, t_nxt;
  logic [CW-1:0] n_q, n_nxt;
  logic          fin_q, fin_nxt;
  logic [31:0]   n_raw;
  logic [CW-1:0] n_sel;
  logic [CW:0]   last_t;
  logic          t_last;
  logic          t_in_data;
  logic          fin_seen;

  vec_t a_mem [SIZE];
  vec_t b_mem [SIZE];

  assign n_raw     = 32'd4 << rf_matrix_size;
  assign n_sel     = (n_raw >= 32'(SIZE)) ? CW'(SIZE) : n_raw[CW-1:0];
  assign last_t    = {n_q, 1'b0} - (CW+1)'(2);
  assign t_last    = ({1'b0, t_q} == last_t);
  assign t_in_data = (t_q < n_q);
  assign fin_seen  = fin_q | i_first_finish;

  // Stores carry no reset so loaded operands survive reset and completed runs.
  always_ff @(posedge i_clock) begin
    if (i_wr_valid && o_wr_ready) begin
      if (i_wr_sel) b_mem[i_wr_addr] <= i_wr_data;
      else          a_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    n_nxt     = n_q;
    fin_nxt   = fin_q;
    case (state)
      IDLE: begin
        if (i_start) begin
          n_nxt     = n_sel;
          t_nxt     = '0;
          fin_nxt   = 1'b0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: state_nxt = STREAM;
      STREAM: begin
        fin_nxt = fin_seen;
        if (t_last) state_nxt = DRAIN;
        else        t_nxt     = t_q + CW'(1);
      end
      DRAIN: begin
        fin_nxt = fin_seen;
        if (fin_seen) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake/status outputs track the next state; array-facing outputs lag the state by one register stage.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      t_q           <= '0;
      n_q           <= '0;
      fin_q         <= 1'b0;
      o_wr_ready    <= 1'b1;
      o_busy        <= 1'b0;
      o_array_reset <= 1'b0;
      o_valid       <= 1'b0;
      o_a_full      <= '0;
      o_b_full      <= '0;
      o_done        <= 1'b0;
    end else begin
      state         <= state_nxt;
      t_q           <= t_nxt;
      n_q           <= n_nxt;
      fin_q         <= fin_nxt;
      o_wr_ready    <= (state_nxt == IDLE);
      o_busy        <= (state_nxt != IDLE);
      o_array_reset <= (state == CLEAR);
      o_valid       <= (state == STREAM);
      o_a_full      <= (state == STREAM && t_in_data) ? a_mem[t_q[AW-1:0]] : '0;
      o_b_full      <= (state == STREAM && t_in_data) ? b_mem[t_q[AW-1:0]] : '0;
      o_done        <= (state == DRAIN) && fin_seen;
    end
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder: model stores feed a queue of expected stream vectors that is drained as o_valid cycles appear.
module tb_systolic_input_feeder;

  localparam int SIZE   = 32;
  localparam int I_BITS = 8;
  localparam int VW     = SIZE * I_BITS;

  logic                    i_clock;
  logic                    i_reset;
  logic                    i_wr_valid;
  logic                    o_wr_ready;
  logic                    i_wr_sel;
  logic [$clog2(SIZE)-1:0] i_wr_addr;
  logic [VW-1:0]           i_wr_data;
  logic [2:0]              rf_matrix_size;
  logic                    i_start;
  logic                    i_first_finish;
  logic                    o_array_reset;
  logic                    o_valid;
  logic [VW-1:0]           o_a_full;
  logic [VW-1:0]           o_b_full;
  logic                    o_busy;
  logic                    o_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [VW-1:0] ma [SIZE];
  logic [VW-1:0] mb [SIZE];
  logic [VW-1:0] exp_a [$];
  logic [VW-1:0] exp_b [$];

  systolic_input_feeder #(.SIZE(SIZE), .I_BITS(I_BITS)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .i_wr_sel       (i_wr_sel),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .rf_matrix_size (rf_matrix_size),
    .i_start        (i_start),
    .i_first_finish (i_first_finish),
    .o_array_reset  (o_array_reset),
    .o_valid        (o_valid),
    .o_a_full       (o_a_full),
    .o_b_full       (o_b_full),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic logic [VW-1:0] rep(input logic [7:0] b);
    rep = {SIZE{b}};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic wr(input logic sel, input int addr, input logic [VW-1:0] data);
    i_wr_valid = 1'b1;
    i_wr_sel   = sel;
    i_wr_addr  = 5'(addr);
    i_wr_data  = data;
    chk("wr_ready_idle", o_wr_ready, 1'b1);
    tick();
    i_wr_valid = 1'b0;
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
  endtask

  // One full run; fin_at/wr_at/start_at are cycle numbers relative to the start edge (-1 = never).
  task automatic do_run(input int code, input int fin_at, input bit collide,
                        input int wr_at, input int start_at);
    int n, exp_done;
    logic [VW-1:0] ea, eb;
    n        = ((4 << code) > SIZE) ? SIZE : (4 << code);
    exp_done = (fin_at + 1 > 2*n + 1) ? fin_at + 1 : 2*n + 1;
    if (collide) begin
      i_wr_valid = 1'b1;
      i_wr_sel   = 1'b0;
      i_wr_addr  = '0;
      i_wr_data  = rep(8'hFF);
      ma[0]      = rep(8'hFF);
    end
    for (int t = 0; t < 2*n - 1; t++) begin
      exp_a.push_back((t < n) ? ma[t] : '0);
      exp_b.push_back((t < n) ? mb[t] : '0);
    end
    rf_matrix_size = 3'(code);
    i_start        = 1'b1;
    tick();
    for (int cyc = 0; cyc <= exp_done; cyc++) begin
      if (cyc > 0) tick();
      i_first_finish = (cyc == fin_at);
      i_start        = (cyc == start_at);
      i_wr_valid     = (cyc == wr_at);
      i_wr_sel       = 1'b0;
      i_wr_addr      = '0;
      i_wr_data      = rep(8'h55);
      chk("array_reset", o_array_reset, cyc == 1);
      chk("valid",       o_valid,       cyc >= 2 && cyc <= 2*n);
      chk("busy",        o_busy,        cyc < exp_done);
      chk("wr_ready",    o_wr_ready,    cyc >= exp_done);
      chk("done",        o_done,        cyc == exp_done);
      if (o_valid) begin
        ea = (exp_a.size() > 0) ? exp_a.pop_front() : 'x;
        eb = (exp_b.size() > 0) ? exp_b.pop_front() : 'x;
        chk("a_data", o_a_full, ea);
        chk("b_data", o_b_full, eb);
      end else begin
        chk("a_quiet", o_a_full, '0);
        chk("b_quiet", o_b_full, '0);
      end
    end
    i_first_finish = 1'b0;
    i_start        = 1'b0;
    i_wr_valid     = 1'b0;
    chk("sb_left", exp_a.size(), 0);
    tick();
    chk("post_ready", o_wr_ready, 1'b1);
    chk("post_busy",  o_busy,     1'b0);
    chk("post_done",  o_done,     1'b0);
  endtask

  initial begin
    bit seen_done, seen_valid;
    i_reset = 1'b0;
    i_wr_valid = 1'b0; i_wr_sel = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    rf_matrix_size = '0; i_start = 1'b0; i_first_finish = 1'b0;
    #1 i_reset = 1'b1;
    #2;
    chk("rst_ready", o_wr_ready,    1'b1);
    chk("rst_busy",  o_busy,        1'b0);
    chk("rst_valid", o_valid,       1'b0);
    chk("rst_clear", o_array_reset, 1'b0);
    chk("rst_done",  o_done,        1'b0);
    chk("rst_a",     o_a_full,      '0);
    tick();
    i_reset = 1'b0;
    tick();

    for (int k = 0; k < SIZE; k++) begin
      wr(1'b0, k, rep(8'(k + 1)));
      wr(1'b1, k, rep(8'(8'h10 + k)));
    end

    // basic n=4, finish seen mid-stream at cycle 7
    do_run(0, 7, 1'b0, -1, -1);
    // latched finish well before drain, n=8
    do_run(1, 5, 1'b0, -1, -1);
    // write/start collision plus a rejected write during STREAM
    do_run(0, 8, 1'b1, 3, -1);
    do_run(0, 8, 1'b0, -1, -1);
    // saturation: code 5 -> n=32, stray start mid-run
    do_run(5, 20, 1'b0, -1, 10);
    // long stall in DRAIN
    do_run(0, 108, 1'b0, -1, -1);

    // asynchronous reset mid-STREAM at n=8
    rf_matrix_size = 3'd1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (6) tick();
    chk("pre_rst_valid", o_valid, 1'b1);
    #2 i_reset = 1'b1;
    #1;
    chk("arst_valid", o_valid,       1'b0);
    chk("arst_a",     o_a_full,      '0);
    chk("arst_b",     o_b_full,      '0);
    chk("arst_ready", o_wr_ready,    1'b1);
    chk("arst_busy",  o_busy,        1'b0);
    chk("arst_clear", o_array_reset, 1'b0);
    tick();
    i_reset = 1'b0;
    seen_done = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) i_first_finish = 1'b1;
      else        i_first_finish = 1'b0;
      tick();
      seen_done  |= o_done;
      seen_valid |= o_valid;
    end
    i_first_finish = 1'b0;
    chk("arst_no_done",  seen_done,  1'b0);
    chk("arst_no_valid", seen_valid, 1'b0);
    exp_a.delete();
    exp_b.delete();
    do_run(0, 7, 1'b0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
